// File: rtl/tx_pkg.sv
// Shared definitions for the TX frame scheduler: FSM state encoding and default field width.
// Pure declarations; no logic, no latency, no flow control.
package tx_pkg;

   localparam int unsigned TX_LEN_WIDTH_DEFAULT = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SEND = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } tx_state_e;

endpackage

// File: rtl/tx_len_counter.sv
// Loadable down-counter with zero flag, used for beat and gap counting.
// Load takes effect on the next edge; decrement holds at zero; load wins over decrement.
module tx_len_counter #(
   parameter int unsigned W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic [W-1:0] o_count,
   output logic         o_zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = i_load_val;
      end else if (i_dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_count = cnt_q;
   assign o_zero  = (cnt_q == '0);

endmodule

// File: rtl/tx_frame_scheduler.sv
// Emits PRBS-filled AXI-Stream frames of configurable length/gap/count; first tvalid 2 cycles after enable.
// Beats hold while tready=0 (PRBS only advances on handshake); gaps are timed independent of tready.
module tx_frame_scheduler
   import tx_pkg::*;
#(
   parameter int unsigned C_LEN_WIDTH  = TX_LEN_WIDTH_DEFAULT,
   parameter int unsigned C_DATA_WIDTH = 32
) (
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_aresetn,
   input  logic                    i_enable,
   input  logic [C_LEN_WIDTH-1:0]  i_frame_len,
   input  logic [C_LEN_WIDTH-1:0]  i_gap_len,
   input  logic [C_LEN_WIDTH-1:0]  i_num_frames,
   output logic                    o_prbs_load,
   output logic                    o_prbs_advance,
   input  logic [C_DATA_WIDTH-1:0] i_prbs_data,
   output logic                    m_axis_tvalid,
   output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tuser,
   input  logic                    m_axis_tready,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [C_LEN_WIDTH-1:0]  o_frame_cnt
);

   tx_state_e              state_q, state_d;
   logic [C_LEN_WIDTH-1:0] len_m1_q, len_m1_d;
   logic [C_LEN_WIDTH-1:0] gap_len_q, gap_len_d;
   logic [C_LEN_WIDTH-1:0] num_q, num_d;
   logic [C_LEN_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
   logic [C_LEN_WIDTH-1:0] frame_cnt_inc;

   logic                   beat_load, beat_dec, beat_zero;
   logic [C_LEN_WIDTH-1:0] beat_cnt;
   logic                   gap_load, gap_dec, gap_zero;
   logic [C_LEN_WIDTH-1:0] gap_cnt;
   logic                   hs;

   // Beat counter holds beats remaining after the current one, so zero marks tlast.
   tx_len_counter #(.W(C_LEN_WIDTH)) u_beat_cnt (
      .i_clk      (s_axi_aclk),
      .i_rst_n    (s_axi_aresetn),
      .i_load     (beat_load),
      .i_load_val (len_m1_q),
      .i_dec      (beat_dec),
      .o_count    (beat_cnt),
      .o_zero     (beat_zero)
   );

   tx_len_counter #(.W(C_LEN_WIDTH)) u_gap_cnt (
      .i_clk      (s_axi_aclk),
      .i_rst_n    (s_axi_aresetn),
      .i_load     (gap_load),
      .i_load_val (gap_len_q - C_LEN_WIDTH'(1)),
      .i_dec      (gap_dec),
      .o_count    (gap_cnt),
      .o_zero     (gap_zero)
   );

   assign hs            = (state_q == ST_SEND) && m_axis_tready;
   assign frame_cnt_inc = frame_cnt_q + C_LEN_WIDTH'(1);

   always_comb begin
      state_d     = state_q;
      len_m1_d    = len_m1_q;
      gap_len_d   = gap_len_q;
      num_d       = num_q;
      frame_cnt_d = frame_cnt_q;
      beat_load   = 1'b0;
      beat_dec    = 1'b0;
      gap_load    = 1'b0;
      gap_dec     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_enable) begin
               len_m1_d  = (i_frame_len == '0) ? '0 : (i_frame_len - C_LEN_WIDTH'(1));
               gap_len_d = i_gap_len;
               num_d     = i_num_frames;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            frame_cnt_d = '0;
            beat_load   = 1'b1;
            state_d     = ST_SEND;
         end
         ST_SEND: begin
            if (hs && beat_zero) begin
               frame_cnt_d = frame_cnt_inc;
               beat_load   = 1'b1;
               if ((num_q != '0) && (frame_cnt_inc == num_q)) begin
                  state_d = ST_DONE;
               end else if (!i_enable) begin
                  state_d = ST_IDLE;
               end else if (gap_len_q == '0) begin
                  state_d = ST_SEND;
               end else begin
                  gap_load = 1'b1;
                  state_d  = ST_GAP;
               end
            end else if (hs) begin
               beat_dec = 1'b1;
            end
         end
         ST_GAP: begin
            if (!i_enable) begin
               state_d = ST_IDLE;
            end else if (gap_zero) begin
               state_d = ST_SEND;
            end else begin
               gap_dec = (gap_cnt != '0);
            end
         end
         ST_DONE: begin
            if (!i_enable) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q     <= ST_IDLE;
         len_m1_q    <= '0;
         gap_len_q   <= '0;
         num_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         len_m1_q    <= len_m1_d;
         gap_len_q   <= gap_len_d;
         num_q       <= num_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign m_axis_tvalid  = (state_q == ST_SEND);
   assign m_axis_tdata   = m_axis_tvalid ? i_prbs_data : '0;
   assign m_axis_tuser   = m_axis_tvalid && (beat_cnt == len_m1_q);
   assign m_axis_tlast   = m_axis_tvalid && beat_zero;
   assign o_prbs_advance = m_axis_tvalid && m_axis_tready;
   assign o_prbs_load    = (state_q == ST_LOAD);
   assign o_busy         = (state_q == ST_LOAD) || (state_q == ST_SEND) || (state_q == ST_GAP);
   assign o_done         = (state_q == ST_DONE);
   assign o_frame_cnt    = frame_cnt_q;

endmodule
